multicycle_control_unit: RTL and testbench

- FSM that sequences the shared single-memory, single-ALU RV32I datapath across IF/ID/EX/MEM/WB.
- Tolerates variable-latency memory through a req/ready handshake.
- Drives the immediate-generator format select, ALU operand and op selects, PC update and register write-back.
- Counts retired instructions and halts on ECALL with the halt condition.

---
 rtl/multicycle_control_unit_pkg.sv | 75 +++++++
 rtl/multicycle_control_unit_output_decode.sv | 82 ++++++++
 rtl/multicycle_control_unit.sv | 109 ++++++++++
 tb/tb_multicycle_control_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, opcodes,
// and the datapath select fields used by ImmGen, ALU muxes, PC and write-back.
package multicycle_control_unit_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_J    = 3'd3,
    IMM_U    = 3'd4,
    IMM_NONE = 3'd7
  } imm_sel_t;

  typedef enum logic [1:0] {SRCA_RS1 = 2'd0, SRCA_PC = 2'd1, SRCA_ZERO = 2'd2} alu_src_a_t;
  typedef enum logic [1:0] {SRCB_RS2 = 2'd0, SRCB_IMM = 2'd1, SRCB_FOUR = 2'd2} alu_src_b_t;
  typedef enum logic [1:0] {ALU_ADD = 2'd0, ALU_FUNCT = 2'd1, ALU_CMP = 2'd2} alu_op_t;
  typedef enum logic [1:0] {WB_ALUOUT = 2'd0, WB_MDR = 2'd1, WB_PC4 = 2'd2} wb_sel_t;
  typedef enum logic [1:0] {PC_PLUS4 = 2'd0, PC_ALUOUT = 2'd1, PC_BRANCH = 2'd2} pc_source_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       reg_write;
    wb_sel_t    wb_sel;
    alu_src_a_t alu_src_a;
    alu_src_b_t alu_src_b;
    alu_op_t    alu_op;
    imm_sel_t   imm_sel;
    logic       pc_write;
    pc_source_t pc_source;
  } ctrl_t;

  function automatic imm_sel_t imm_sel_of(input logic [6:0] opc);
    case (opc)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: return IMM_I;
      OPC_STORE:                      return IMM_S;
      OPC_BRANCH:                     return IMM_B;
      OPC_JAL:                        return IMM_J;
      OPC_LUI, OPC_AUIPC:             return IMM_U;
      default:                        return IMM_NONE;
    endcase
  endfunction

  // Unknown opcodes (including a non-halting SYSTEM) execute as a NOP.
  function automatic logic opcode_known(input logic [6:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_unit_output_decode.sv
// Combinational state+opcode to control-signal decode for the multicycle unit;
// also flags the cycle in which an instruction retires.
module mcu_output_decode
  import multicycle_control_unit_pkg::*;
(
  input  state_t     state_i,
  input  logic [6:0] opcode_i,
  input  logic       bcond_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o,
  output logic       retire_o
);

  always_comb begin
    ctrl_o         = '0;
    retire_o       = 1'b0;
    ctrl_o.imm_sel = (state_i == S_IF) ? IMM_NONE : imm_sel_of(opcode_i);

    case (state_i)
      S_IF: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b0;
        ctrl_o.ir_write = mem_ready_i;
      end
      S_EX: begin
        case (opcode_i)
          OPC_OP:     ctrl_o.alu_op = ALU_FUNCT;
          OPC_OP_IMM: begin
            ctrl_o.alu_op    = ALU_FUNCT;
            ctrl_o.alu_src_b = SRCB_IMM;
          end
          OPC_LOAD, OPC_STORE: ctrl_o.alu_src_b = SRCB_IMM;
          OPC_BRANCH: begin
            ctrl_o.alu_op    = ALU_CMP;
            ctrl_o.pc_write  = 1'b1;
            ctrl_o.pc_source = bcond_i ? PC_BRANCH : PC_PLUS4;
            retire_o         = 1'b1;
          end
          OPC_JAL, OPC_AUIPC: begin
            ctrl_o.alu_src_a = SRCA_PC;
            ctrl_o.alu_src_b = SRCB_IMM;
          end
          OPC_JALR: ctrl_o.alu_src_b = SRCB_IMM;
          OPC_LUI: begin
            ctrl_o.alu_src_a = SRCA_ZERO;
            ctrl_o.alu_src_b = SRCB_IMM;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        ctrl_o.i_or_d = 1'b1;
        if (opcode_i == OPC_STORE) begin
          ctrl_o.mem_write = 1'b1;
          ctrl_o.pc_write  = mem_ready_i;
          retire_o         = mem_ready_i;
        end else begin
          ctrl_o.mem_read = 1'b1;
        end
      end
      S_WB: begin
        ctrl_o.reg_write = opcode_known(opcode_i);
        ctrl_o.pc_write  = 1'b1;
        retire_o         = 1'b1;
        case (opcode_i)
          OPC_LOAD: ctrl_o.wb_sel = WB_MDR;
          OPC_JAL: begin
            ctrl_o.wb_sel    = WB_PC4;
            ctrl_o.pc_source = PC_BRANCH;
          end
          OPC_JALR: begin
            ctrl_o.wb_sel    = WB_PC4;
            ctrl_o.pc_source = PC_ALUOUT;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM: IF/ID/EX/MEM/WB sequencing with a req/ready
// memory handshake, retired-instruction counter and sticky ECALL halt.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic                 bcond,
  input  logic                 halt_req,
  input  logic                 mem_ready,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 i_or_d,
  output logic                 ir_write,
  output logic                 reg_write,
  output logic [1:0]           wb_sel,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic [2:0]           imm_sel,
  output logic                 pc_write,
  output logic [1:0]           pc_source,
  output logic                 is_halt,
  output logic [CNT_WIDTH-1:0] retired
);

  state_t               state_q, state_d;
  logic                 is_halt_q;
  logic [CNT_WIDTH-1:0] retired_q;
  ctrl_t                ctrl;
  logic                 retire;

  mcu_output_decode u_decode (
    .state_i    (state_q),
    .opcode_i   (opcode),
    .bcond_i    (bcond),
    .mem_ready_i(mem_ready),
    .ctrl_o     (ctrl),
    .retire_o   (retire)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF:   if (mem_ready) state_d = S_ID;
      S_ID:   state_d = (halt_req && opcode == OPC_SYSTEM) ? S_HALT : S_EX;
      S_EX: begin
        case (opcode)
          OPC_BRANCH:          state_d = S_IF;
          OPC_LOAD, OPC_STORE: state_d = S_MEM;
          default:             state_d = S_WB;
        endcase
      end
      S_MEM:  if (mem_ready) state_d = (opcode == OPC_STORE) ? S_IF : S_WB;
      S_WB:   state_d = S_IF;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IF;
      is_halt_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      is_halt_q <= (state_d == S_HALT);
      if (retire) retired_q <= retired_q + CNT_WIDTH'(1);
    end
  end

  // Decoded outputs are Mealy, so they must be gated to hold 0 while reset is low.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    i_or_d    = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    wb_sel    = '0;
    alu_src_a = '0;
    alu_src_b = '0;
    alu_op    = '0;
    imm_sel   = '0;
    pc_write  = 1'b0;
    pc_source = '0;
    if (reset) begin
      mem_read  = ctrl.mem_read;
      mem_write = ctrl.mem_write;
      i_or_d    = ctrl.i_or_d;
      ir_write  = ctrl.ir_write;
      reg_write = ctrl.reg_write;
      wb_sel    = ctrl.wb_sel;
      alu_src_a = ctrl.alu_src_a;
      alu_src_b = ctrl.alu_src_b;
      alu_op    = ctrl.alu_op;
      imm_sel   = ctrl.imm_sel;
      pc_write  = ctrl.pc_write;
      pc_source = ctrl.pc_source;
    end
  end

  assign is_halt = is_halt_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed and randomized instructions with
// random memory wait states, checked every cycle against a per-phase model.
module tb_multicycle_control_unit;

  localparam int CW = 4;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam logic [6:0] OP_SYS   = 7'b1110011;
  localparam logic [6:0] OP_BAD   = 7'b1111111;

  typedef enum {P_RST, P_IF, P_ID, P_EX, P_MEM, P_WB, P_HALT} phase_e;

  typedef struct packed {
    logic       mr, mw, iod, irw, rw;
    logic [1:0] wb, sa, sb, aop;
    logic [2:0] imm;
    logic       pcw;
    logic [1:0] pcs;
    logic       halt;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [6:0]    opcode = '0;
  logic          bcond = 1'b0, halt_req = 1'b0, mem_ready = 1'b0;
  logic          mem_read, mem_write, i_or_d, ir_write, reg_write, pc_write, is_halt;
  logic [1:0]    wb_sel, alu_src_a, alu_src_b, alu_op, pc_source;
  logic [2:0]    imm_sel;
  logic [CW-1:0] retired;

  int unsigned vectors = 0;
  int unsigned fails = 0;
  int unsigned model_ret = 0;
  logic [6:0]  cur_op = '0;
  logic        cur_bc = 1'b0, cur_hreq = 1'b0;
  logic [6:0]  ops [0:11];

  multicycle_control_unit #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond), .halt_req(halt_req),
    .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .ir_write(ir_write), .reg_write(reg_write), .wb_sel(wb_sel), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_sel(imm_sel), .pc_write(pc_write),
    .pc_source(pc_source), .is_halt(is_halt), .retired(retired)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    case (op)
      OP_IMM, OP_LOAD, OP_JALR: return 3'd0;
      OP_STORE:                 return 3'd1;
      OP_BR:                    return 3'd2;
      OP_JAL:                   return 3'd3;
      OP_LUI, OP_AUIPC:         return 3'd4;
      default:                  return 3'd7;
    endcase
  endfunction

  function automatic logic known(input logic [6:0] op);
    return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR, OP_LOAD, OP_STORE, OP_IMM, OP_ALU};
  endfunction

  function automatic vec_t observe();
    return {mem_read, mem_write, i_or_d, ir_write, reg_write, wb_sel, alu_src_a,
            alu_src_b, alu_op, imm_sel, pc_write, pc_source, is_halt};
  endfunction

  task automatic check(input string tag, input vec_t exp_v);
    vec_t          obs_v;
    logic [CW-1:0] exp_r;
    obs_v = observe();
    exp_r = model_ret[CW-1:0];
    vectors++;
    assert (obs_v === exp_v) else begin
      fails++;
      $error("FAIL %s ctrl: observed %h expected %h", tag, obs_v, exp_v);
    end
    vectors++;
    assert (retired === exp_r) else begin
      fails++;
      $error("FAIL %s retired: observed %0d expected %0d", tag, retired, exp_r);
    end
  endtask

  // One clock cycle of the given pipeline phase: drive, settle, compare.
  task automatic cycle(input phase_e ph, input logic rdy);
    vec_t e;
    logic ret;
    @(negedge clk);
    reset     = (ph != P_RST);
    opcode    = (ph == P_IF) ? 7'($urandom) : cur_op;
    mem_ready = (ph == P_IF || ph == P_MEM) ? rdy : 1'($urandom);
    bcond     = (ph == P_EX) ? cur_bc : 1'($urandom);
    halt_req  = (ph == P_ID) ? cur_hreq : 1'($urandom);
    #1;
    e     = '0;
    ret   = 1'b0;
    e.imm = (ph == P_IF) ? 3'd7 : imm_of(cur_op);
    case (ph)
      P_RST: e = '0;
      P_IF: begin
        e.mr  = 1'b1;
        e.irw = rdy;
      end
      P_EX: begin
        case (cur_op)
          OP_ALU:            e.aop = 2'd1;
          OP_IMM:            begin e.aop = 2'd1; e.sb = 2'd1; end
          OP_LOAD, OP_STORE: e.sb = 2'd1;
          OP_BR: begin
            e.aop = 2'd2;
            e.pcw = 1'b1;
            e.pcs = cur_bc ? 2'd2 : 2'd0;
            ret   = 1'b1;
          end
          OP_JAL, OP_AUIPC:  begin e.sa = 2'd1; e.sb = 2'd1; end
          OP_JALR:           e.sb = 2'd1;
          OP_LUI:            begin e.sa = 2'd2; e.sb = 2'd1; end
          default: ;
        endcase
      end
      P_MEM: begin
        e.iod = 1'b1;
        if (cur_op == OP_STORE) begin
          e.mw  = 1'b1;
          e.pcw = rdy;
          ret   = rdy;
        end else begin
          e.mr = 1'b1;
        end
      end
      P_WB: begin
        e.rw  = known(cur_op);
        e.pcw = 1'b1;
        ret   = 1'b1;
        if (cur_op == OP_LOAD) e.wb = 2'd1;
        if (cur_op == OP_JAL)  begin e.wb = 2'd2; e.pcs = 2'd2; end
        if (cur_op == OP_JALR) begin e.wb = 2'd2; e.pcs = 2'd1; end
      end
      P_HALT: e.halt = 1'b1;
      default: ;
    endcase
    check($sformatf("%s@%0t", ph.name(), $time), e);
    if (ret) model_ret = (model_ret + 1) % (1 << CW);
  endtask

  task automatic run_instr(input logic [6:0] op, input logic bc, input int unsigned wif,
                           input int unsigned wmem, input logic hreq);
    cur_op   = op;
    cur_bc   = bc;
    cur_hreq = hreq;
    for (int unsigned i = 0; i <= wif; i++) cycle(P_IF, i == wif);
    cycle(P_ID, 1'b0);
    if (hreq && op == OP_SYS) begin
      for (int i = 0; i < 4; i++) cycle(P_HALT, 1'b0);
      return;
    end
    cycle(P_EX, 1'b0);
    if (op == OP_BR) return;
    if (op == OP_LOAD || op == OP_STORE)
      for (int unsigned i = 0; i <= wmem; i++) cycle(P_MEM, i == wmem);
    if (op == OP_STORE) return;
    cycle(P_WB, 1'b0);
  endtask

  initial begin
    ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR, OP_LOAD, OP_STORE,
            OP_IMM, OP_ALU, OP_SYS, OP_BAD, OP_LOAD};

    model_ret = 0;
    for (int i = 0; i < 3; i++) cycle(P_RST, 1'b1);
    run_instr(OP_IMM,  1'b0, 0, 0, 1'b0);
    run_instr(OP_LOAD, 1'b0, 3, 3, 1'b0);
    run_instr(OP_BR,   1'b1, 0, 0, 1'b0);
    run_instr(OP_BR,   1'b0, 0, 0, 1'b0);
    run_instr(OP_JALR, 1'b0, 0, 0, 1'b0);
    run_instr(OP_LUI,  1'b0, 0, 0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      logic [6:0] op;
      op = ops[$urandom_range(0, 11)];
      run_instr(op, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                (op == OP_SYS) ? 1'b0 : 1'($urandom));
    end

    model_ret = 0;
    for (int i = 0; i < 2; i++) cycle(P_RST, 1'b1);
    run_instr(OP_ALU,   1'b0, 0, 0, 1'b0);
    run_instr(OP_STORE, 1'b0, 1, 2, 1'b0);
    run_instr(OP_SYS,   1'b0, 1, 0, 1'b1);

    // Reset dropped between clock edges must clear halt and counter at once.
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    model_ret = 0;
    check("async_reset_in_halt", '0);
    for (int i = 0; i < 2; i++) cycle(P_RST, 1'b1);
    run_instr(OP_AUIPC, 1'b0, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
